// File: rtl/show_pkg.sv
// Shared constants and types for the debug-frame UART transmitter.
// FRAME_BYTES sets the snapshot width; LEN_W is wide enough to carry 0..FRAME_BYTES.
package show_pkg;

  localparam int FRAME_BYTES = 16;
  localparam int LEN_W       = 5;
  localparam int UART_BITS   = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    FINISH = 3'd4
  } show_tx_state_t;

  // Requests longer than the frame are treated as a full frame.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] max_len);
    logic [LEN_W-1:0] res;
    if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/show_uart_tx_if.sv
// Request/status bundle between the debug-frame producer and the UART transmitter.
// The producer holds the master modport, the transmitter the slave modport.
interface show_uart_tx_if #(
  parameter int FRAME_BYTES = show_pkg::FRAME_BYTES
);
  import show_pkg::*;

  logic                     send;
  logic [8*FRAME_BYTES-1:0] data;
  logic [LEN_W-1:0]         len;
  logic                     txd;
  logic                     busy;
  logic                     done;
  logic [7:0]               drop_cnt;

  modport master (
    output send, data, len,
    input  txd, busy, done, drop_cnt
  );

  modport slave (
    input  send, data, len,
    output txd, busy, done, drop_cnt
  );

endinterface

// File: rtl/show_uart_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Restart holds it at zero so the first bit after a restart gets a full period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q;

  assign tick = (cnt_q == LAST);

  // bit-period counter, wraps on its own at every bit boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else if (restart || tick) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/show_uart_tx.sv
// 8N1 serialiser for the debug frame: snapshots data/len on accept and sends the
// valid bytes highest index first, each LSB first, with busy/done status and a drop counter.
module show_uart_tx
  import show_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FRAME_BYTES  = show_pkg::FRAME_BYTES
) (
  input  logic            clk,
  input  logic            reset,
  show_uart_tx_if.slave   bus
);

  localparam int DATA_W = 8 * FRAME_BYTES;
  localparam int IDX_W  = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(FRAME_BYTES);

  show_tx_state_t     state_q;
  logic               txd_q;
  logic               busy_q;
  logic               done_q;
  logic [7:0]         drop_cnt_q;
  logic [7:0]         drop_cnt_d;
  logic [DATA_W-1:0]  frame_q;
  logic [7:0]         shift_q;
  logic [2:0]         bit_idx_q;
  logic [IDX_W-1:0]   byte_idx_q;

  logic [LEN_W-1:0]   len_clamped_s;
  logic [LEN_W-1:0]   len_m1_s;
  logic [IDX_W-1:0]   first_idx_s;
  logic [IDX_W-1:0]   prev_idx_s;
  logic [7:0]         first_byte_s;
  logic [7:0]         next_byte_s;
  logic               timer_restart_s;
  logic               tick_s;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .restart(timer_restart_s),
    .tick   (tick_s)
  );

  // byte selection, timer control and drop-counter next state
  always_comb begin
    len_clamped_s   = clamp_len(bus.len, MAX_LEN);
    len_m1_s        = len_clamped_s - {{(LEN_W-1){1'b0}}, 1'b1};
    first_idx_s     = len_m1_s[IDX_W-1:0];
    prev_idx_s      = byte_idx_q - {{(IDX_W-1){1'b0}}, 1'b1};
    first_byte_s    = bus.data[{first_idx_s, 3'b000} +: 8];
    next_byte_s     = frame_q[{prev_idx_s, 3'b000} +: 8];
    timer_restart_s = (state_q == IDLE) || (state_q == FINISH);
    if (bus.send && busy_q && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // transmit FSM with registered line and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_cnt_q <= 8'd0;
      frame_q    <= '0;
      shift_q    <= 8'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
          if (bus.send) begin
            frame_q    <= bus.data;
            busy_q     <= 1'b1;
            byte_idx_q <= first_idx_s;
            shift_q    <= first_byte_s;
            bit_idx_q  <= 3'd0;
            if (len_clamped_s == '0) begin
              // empty frame: a lone FINISH cycle, line never leaves idle
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= START;
              txd_q   <= 1'b0;
            end
          end
        end
        START: begin
          if (tick_s) begin
            state_q   <= DATA;
            txd_q     <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= 3'd0;
          end
        end
        DATA: begin
          if (tick_s) begin
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              txd_q     <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (tick_s) begin
            if (byte_idx_q == '0) begin
              state_q <= FINISH;
              txd_q   <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q    <= START;
              byte_idx_q <= prev_idx_s;
              shift_q    <= next_byte_s;
              txd_q      <= 1'b0;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          txd_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.txd      = txd_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_show_uart_tx.sv
// Randomised bench for show_uart_tx: a waveform-level model expands each accepted
// frame into expected per-cycle line/status values and is compared every cycle.
module tb_show_uart_tx;
  import show_pkg::*;

  localparam int C = 4;

  typedef struct packed {
    logic txd;
    logic busy;
    logic done;
  } exp_t;

  localparam exp_t IDLE_E = '{txd: 1'b1, busy: 1'b0, done: 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  show_uart_tx_if #(.FRAME_BYTES(FRAME_BYTES)) bus ();

  show_uart_tx #(
    .CLKS_PER_BIT(C),
    .FRAME_BYTES (FRAME_BYTES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  exp_t       q[$];
  exp_t       cur = IDLE_E;
  logic [7:0] m_drop = 8'd0;
  bit         chk_en = 1'b0;

  function automatic void build_frame(input logic [4:0] l, input logic [127:0] d);
    int n;
    n = (l > 5'd16) ? 16 : int'(l);
    for (int b = n - 1; b >= 0; b--) begin
      logic [7:0] by;
      by = d[8*b +: 8];
      for (int k = 0; k < UART_BITS; k++) begin
        logic bv;
        if (k == 0) bv = 1'b0;
        else if (k == UART_BITS - 1) bv = 1'b1;
        else bv = by[k-1];
        for (int c = 0; c < C; c++) q.push_back(exp_t'{txd: bv, busy: 1'b1, done: 1'b0});
      end
    end
    q.push_back(exp_t'{txd: 1'b1, busy: 1'b1, done: 1'b1});
  endfunction

  // compare current cycle, then advance the model with the inputs the next edge will sample
  always @(negedge clk) begin
    if (chk_en) begin
      check("txd", {31'd0, bus.txd}, {31'd0, cur.txd});
      check("busy", {31'd0, bus.busy}, {31'd0, cur.busy});
      check("done", {31'd0, bus.done}, {31'd0, cur.done});
      check("drop_cnt", {24'd0, bus.drop_cnt}, {24'd0, m_drop});
    end
    if (reset) begin
      q.delete();
      cur    = IDLE_E;
      m_drop = 8'd0;
      chk_en = 1'b1;
    end else begin
      if (bus.send && cur.busy && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      if (bus.send && !cur.busy) build_frame(bus.len, bus.data);
      if (q.size() > 0) cur = q.pop_front();
      else cur = IDLE_E;
    end
  end

  // ---------------- stimulus ----------------
  logic txd_log[700];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_frame(input logic [4:0] l, input logic [127:0] d,
                           output int busy_n, output int done_idx);
    bus.send = 1'b1;
    bus.len  = l;
    bus.data = d;
    tick();
    bus.send = 1'b0;
    bus.len  = 5'($urandom_range(0, 31));
    bus.data = rnd128();
    busy_n   = 0;
    done_idx = -1;
    while (bus.busy === 1'b1 && busy_n < 2000) begin
      if (busy_n < 700) txd_log[busy_n] = bus.txd;
      if (bus.done === 1'b1) done_idx = busy_n;
      busy_n++;
      tick();
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 2000) begin
      n++;
      tick();
    end
    if (n >= 2000) check(name, 32'd1, 32'd0);
  endtask

  initial begin
    int bn, di, seen_done;
    logic [127:0] d4;
    bit pat[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    bus.send = 1'b0;
    bus.len  = 5'd0;
    bus.data = '0;
    repeat (3) tick();
    reset = 1'b0;

    // T1: idle after reset
    repeat (20) tick();
    check("t1_txd", {31'd0, bus.txd}, 32'd1);
    check("t1_busy", {31'd0, bus.busy}, 32'd0);
    check("t1_drop", {24'd0, bus.drop_cnt}, 32'd0);

    // T2: four bytes 12,01,00,00
    run_frame(5'd4, 128'h1201_0000, bn, di);
    check("t2_busy_cycles", bn, 32'd161);
    check("t2_done_idx", di, 32'd160);
    for (int k = 0; k < 10; k++) begin
      check("t2_bit_first", {31'd0, txd_log[4*k]}, {31'd0, pat[k]});
      check("t2_bit_last", {31'd0, txd_log[4*k+3]}, {31'd0, pat[k]});
    end
    repeat (2) tick();

    // T3: empty frame
    run_frame(5'd0, rnd128(), bn, di);
    check("t3_busy_cycles", bn, 32'd1);
    check("t3_done_idx", di, 32'd0);
    check("t3_txd", {31'd0, txd_log[0]}, 32'd1);
    repeat (2) tick();

    // T4: full frame, byte i = i
    for (int i = 0; i < 16; i++) d4[8*i +: 8] = 8'(i);
    run_frame(5'd16, d4, bn, di);
    check("t4_busy_cycles", bn, 32'd641);
    check("t4_done_idx", di, 32'd640);
    check("t4_start", {31'd0, txd_log[0]}, 32'd0);
    check("t4_bit0", {31'd0, txd_log[4]}, 32'd1);
    check("t4_last_byte_bit0", {31'd0, txd_log[600+4]}, 32'd0);

    // oversize length clamps to 16
    run_frame(5'd25, rnd128(), bn, di);
    check("clamp_busy_cycles", bn, 32'd641);
    repeat (1) tick();

    // randomised frames with drops and input churn while busy
    for (int it = 0; it < 25; it++) begin
      int hold;
      int guard;
      repeat ($urandom_range(0, 5)) tick();
      bus.len  = 5'($urandom_range(0, 20));
      bus.data = rnd128();
      bus.send = 1'b1;
      hold = $urandom_range(1, 3);
      repeat (hold) tick();
      bus.send = 1'b0;
      guard = 0;
      while (bus.busy === 1'b1 && guard < 2000) begin
        bus.send = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) == 0) begin
          bus.data = rnd128();
          bus.len  = 5'($urandom_range(0, 31));
        end
        guard++;
        tick();
      end
      bus.send = 1'b0;
      tick();
      wait_idle("rand_idle_timeout");
    end

    // T5: continuous send saturates the drop counter
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.len  = 5'd2;
    bus.data = rnd128();
    bus.send = 1'b1;
    repeat (300) tick();
    bus.send = 1'b0;
    check("t5_drop_sat", {24'd0, bus.drop_cnt}, 32'hFF);
    wait_idle("t5_idle_timeout");
    tick();

    // T6: reset during byte 2 of a 12-byte frame
    bus.len  = 5'd12;
    bus.data = rnd128();
    bus.send = 1'b1;
    tick();
    bus.send = 1'b0;
    repeat (55) tick();
    check("t6_busy_before", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_txd_after", {31'd0, bus.txd}, 32'd1);
    check("t6_busy_after", {31'd0, bus.busy}, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.done === 1'b1) seen_done++;
      tick();
    end
    check("t6_no_done", seen_done, 32'd0);
    run_frame(5'd3, rnd128(), bn, di);
    check("t6_fresh_busy_cycles", bn, 32'd121);
    check("t6_fresh_done_idx", di, 32'd120);

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
